mram_access_sequencer: RTL

Sequences parallel MRAM read/write cycles from commands decoded by the I2C slave controller. Accepts one command (direction, 20-bit start address, optional burst of up to 16 words), generates CE_n/WE_n/OE_n strobes with programmable pulse widths, and auto-increments the address per beat. It sits between the I2C slave controller and the MRAM pins. It returns read words to the slave on `rd_data`/`rd_data_valid`, which feed `data_from_MRAM`.

---
 rtl/mram_access_sequencer_if.sv | 44 ++++
 rtl/mram_access_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mram_access_sequencer_if.sv
// Bundle of command, write-data, read-data and MRAM pin signals between the
// I2C slave controller side and the MRAM access sequencer.
interface mram_access_sequencer_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready;
    // the sender holds payload stable while valid is high and ready is low.
    // rd_data_valid has no ready: the consumer must take every pulse.
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_burst_en;
    logic [3:0]        cmd_burst_len;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              err_timeout;
    logic              mram_ce_n;
    logic              mram_we_n;
    logic              mram_oe_n;
    logic [ADDR_W-1:0] mram_addr;
    logic [DATA_W-1:0] mram_dq_o;
    logic              mram_dq_oe;
    logic [DATA_W-1:0] mram_dq_i;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_burst_en, cmd_burst_len,
        input  wr_data_valid, wr_data, mram_dq_i,
        output cmd_ready, wr_data_ready, rd_data_valid, rd_data, busy, err_timeout,
        output mram_ce_n, mram_we_n, mram_oe_n, mram_addr, mram_dq_o, mram_dq_oe
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_burst_en, cmd_burst_len,
        output wr_data_valid, wr_data, mram_dq_i,
        input  cmd_ready, wr_data_ready, rd_data_valid, rd_data, busy, err_timeout,
        input  mram_ce_n, mram_we_n, mram_oe_n, mram_addr, mram_dq_o, mram_dq_oe
    );
endinterface

// File: rtl/mram_access_sequencer.sv
// Parallel MRAM read/write cycle sequencer with burst auto-increment.
// Optional macro MRAM_SEQ_TIMEOUT_EN: abort a write after 255 idle WR_WAIT cycles.
module mram_access_sequencer #(
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int WR_CYCLES  = 4,
    parameter int RD_CYCLES  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mram_access_sequencer_if.slave bus,
    output logic [2:0]             dbg_state_o
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_WAIT   = 3'd1,
        S_WR_SETUP  = 3'd2,
        S_WR_PULSE  = 3'd3,
        S_WR_HOLD   = 3'd4,
        S_RD_STROBE = 3'd5,
        S_RD_DONE   = 3'd6,
        S_GAP       = 3'd7
    } state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [3:0]        beats_q;
    logic              accept;
    logic              wr_hs;
    logic              timeout;

    assign accept = (state_q == S_IDLE) && bus.cmd_valid;
    assign wr_hs  = (state_q == S_WR_WAIT) && bus.wr_data_valid;

`ifdef MRAM_SEQ_TIMEOUT_EN
    logic [7:0] to_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q != S_WR_WAIT || wr_hs) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 8'd1;
        end
    end

    // Counter value 254 marks the 255th consecutive WR_WAIT cycle without data.
    assign timeout = (state_q == S_WR_WAIT) && !bus.wr_data_valid && (to_cnt_q == 8'd254);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = bus.cmd_write ? S_WR_WAIT : S_RD_STROBE;
                    cnt_d   = RD_LOAD;
                end
            end
            S_WR_WAIT: begin
                if (timeout) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else if (bus.wr_data_valid) begin
                    state_d = S_WR_SETUP;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = WR_LOAD;
            end
            S_WR_PULSE: begin
                if (cnt_q == '0) state_d = S_WR_HOLD;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WR_HOLD: begin
                if (beats_q != 4'd0) begin
                    state_d = S_WR_WAIT;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_RD_STROBE: begin
                if (cnt_q == '0) state_d = S_RD_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_RD_DONE: begin
                if (beats_q != 4'd0) begin
                    state_d = S_RD_STROBE;
                    cnt_d   = RD_LOAD;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // beats_q counts beats remaining after the current one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
            beats_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.cmd_addr;
                beats_q <= bus.cmd_burst_en ? bus.cmd_burst_len : 4'd0;
            end
            if (wr_hs) begin
                data_q <= bus.wr_data;
            end
            if ((state_q == S_WR_HOLD || state_q == S_RD_DONE) && beats_q != 4'd0) begin
                addr_q  <= addr_q + 1'b1;
                beats_q <= beats_q - 4'd1;
            end
            if (state_q == S_RD_STROBE && cnt_q == '0) begin
                rd_data_q <= bus.mram_dq_i;
            end
        end
    end

    // CE_n stays low for the whole command so a write-data stall keeps the chip selected.
    always_comb begin
        bus.cmd_ready     = 1'b0;
        bus.wr_data_ready = 1'b0;
        bus.rd_data_valid = 1'b0;
        bus.mram_ce_n     = 1'b1;
        bus.mram_we_n     = 1'b1;
        bus.mram_oe_n     = 1'b1;
        bus.mram_dq_oe    = 1'b0;
        case (state_q)
            S_IDLE:      bus.cmd_ready = 1'b1;
            S_WR_WAIT: begin
                bus.wr_data_ready = 1'b1;
                bus.mram_ce_n     = 1'b0;
            end
            S_WR_SETUP: begin
                bus.mram_ce_n  = 1'b0;
                bus.mram_dq_oe = 1'b1;
            end
            S_WR_PULSE: begin
                bus.mram_ce_n  = 1'b0;
                bus.mram_we_n  = 1'b0;
                bus.mram_dq_oe = 1'b1;
            end
            S_WR_HOLD: begin
                bus.mram_ce_n  = 1'b0;
                bus.mram_dq_oe = 1'b1;
            end
            S_RD_STROBE: begin
                bus.mram_ce_n = 1'b0;
                bus.mram_oe_n = 1'b0;
            end
            S_RD_DONE: begin
                bus.mram_ce_n     = 1'b0;
                bus.rd_data_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.err_timeout = timeout;
    assign bus.mram_addr   = addr_q;
    assign bus.mram_dq_o   = data_q;
    assign bus.rd_data     = rd_data_q;
    assign dbg_state_o     = state_q;
endmodule
